// File: rtl/conv_window_scheduler.sv
// ---------------------------------------------------------------------------
// conv_window_scheduler
//
// Walks the 5x5 window reader over every valid convolution position of a
// square frame in row-major order. For each position it restarts the reader,
// waits for the reader's stop pulse, then offers the frozen window to the MAC
// stage over a valid/ready handshake before moving to the next position.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               1-cycle pulse, begins a frame scan (IDLE only)
//   abort               synchronous abort back to IDLE
//   win_en              enable to the window reader (ISSUE/FETCH)
//   win_restart         1-cycle restart pulse to the window reader
//   win_row, win_col    top-left corner of the current window
//   win_stop            reader done pulse
//   win_valid, win_ready  window handshake towards the MAC stage
//   win_index           linear position row*OUT_W+col for result-RAM addressing
//   busy                high whenever the scheduler is not IDLE
//   done                1-cycle pulse after the last window is accepted
//   err                 sticky reader timeout flag, cleared by start or reset
// ---------------------------------------------------------------------------
module conv_window_scheduler #(
    parameter int IMG_W   = 28,
    parameter int K       = 5,
    parameter int TIMEOUT = 127
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       win_en,
    output logic       win_restart,
    output logic [4:0] win_row,
    output logic [4:0] win_col,
    input  logic       win_stop,
    output logic       win_valid,
    input  logic       win_ready,
    output logic [9:0] win_index,
    output logic       busy,
    output logic       done,
    output logic       err
);

    // state     | meaning
    // ----------+--------------------------------------------------------
    // S_IDLE    | waiting for start
    // S_ISSUE   | restart pulse to reader, timeout counter cleared
    // S_FETCH   | reader running, counting towards timeout
    // S_HAND    | reader frozen, window offered to MAC (win_valid)
    // S_ADVANCE | step col/row to the next position
    // S_DONE    | done pulse, back to IDLE

    localparam int         OUT_W    = IMG_W - K + 1;
    localparam logic [4:0] LAST_POS = 5'(OUT_W - 1);
    localparam logic [9:0] OUT_W_10 = 10'(OUT_W);
    localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_FETCH,
        S_HAND,
        S_ADVANCE,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] row_q, row_d;
    logic [4:0] col_q, col_d;
    logic [7:0] cnt_q, cnt_d;
    logic [9:0] index_q, index_d;
    logic       err_q, err_d;
    logic       en_q, en_d;
    logic       restart_q, restart_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        if (abort) begin
            // err is deliberately left alone so a timeout survives an abort.
            state_d = S_IDLE;
            row_d   = '0;
            col_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_ISSUE;
                        row_d   = '0;
                        col_d   = '0;
                        err_d   = 1'b0;
                    end
                end
                S_ISSUE: begin
                    // win_stop seen here is left over from the previous fetch.
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end
                S_FETCH: begin
                    // A stop arriving on the expiry cycle still counts as success.
                    if (win_stop) begin
                        state_d = S_HAND;
                    end else if (cnt_q == TO_LAST) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                        row_d   = '0;
                        col_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                S_HAND: begin
                    // win_valid is high for the whole of HAND.
                    if (win_ready) begin
                        state_d = S_ADVANCE;
                    end
                end
                S_ADVANCE: begin
                    if (col_q < LAST_POS) begin
                        col_d   = col_q + 5'd1;
                        state_d = S_ISSUE;
                    end else begin
                        col_d = '0;
                        if (row_q < LAST_POS) begin
                            row_d   = row_q + 5'd1;
                            state_d = S_ISSUE;
                        end else begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    row_d   = '0;
                    col_d   = '0;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up with the
    // state register rather than trailing it by a cycle.
    always_comb begin
        en_d      = (state_d == S_ISSUE) || (state_d == S_FETCH);
        restart_d = (state_d == S_ISSUE);
        valid_d   = (state_d == S_HAND);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        index_d   = 10'(row_d) * OUT_W_10 + 10'(col_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            cnt_q     <= '0;
            index_q   <= '0;
            err_q     <= 1'b0;
            en_q      <= 1'b0;
            restart_q <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            cnt_q     <= cnt_d;
            index_q   <= index_d;
            err_q     <= err_d;
            en_q      <= en_d;
            restart_q <= restart_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign win_en      = en_q;
    assign win_restart = restart_q;
    assign win_row     = row_q;
    assign win_col     = col_q;
    assign win_valid   = valid_q;
    assign win_index   = index_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule
